// File: rtl/alu_share_arb_if.sv
// Handshake and ALU bus for alu_share_arb: two requester ports plus the shared ALU port.
// The client side (requesters and the ALU itself) uses "master"; the arbiter uses "slave".
interface alu_share_arb_if #(
    parameter int WIDTH = 5
);
    logic             req0;
    logic             req1;
    logic [2:0]       op0;
    logic [2:0]       op1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] res;
    logic             res_flag;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_start;
    logic [WIDTH-1:0] alu_res;
    logic             alu_flag;
    logic             busy;

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, alu_res, alu_flag,
        input  gnt0, gnt1, done0, done1, res, res_flag,
        input  alu_op, alu_a, alu_b, alu_start, busy
    );

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, alu_res, alu_flag,
        output gnt0, gnt1, done0, done1, res, res_flag,
        output alu_op, alu_a, alu_b, alu_start, busy
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters (IDLE/EXEC FSM).
// Optional ALU_ARB_STATS_EN adds saturating 8-bit grant counters cnt0_o/cnt1_o.
module alu_share_arb #(
    parameter int WIDTH = 5,
    parameter int LAT   = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_share_arb_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]     cnt0_o,
    output logic [7:0]     cnt1_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic             last_q;
    logic             owner_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             done0_q;
    logic             done1_q;
    logic             start_q;
    logic             busy_q;
    logic [WIDTH-1:0] res_q;
    logic             flag_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             any_req_d;
    logic             win1_d;

    // Winner selection: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        any_req_d = bus.req0 | bus.req1;
        win1_d    = 1'b0;
        if (bus.req0 && bus.req1) begin
            win1_d = ~last_q;
        end else if (bus.req1) begin
            win1_d = 1'b1;
        end else begin
            win1_d = 1'b0;
        end
    end

    // Control FSM with all outputs registered; strobes default low every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            res_q   <= '0;
            flag_q  <= 1'b0;
            op_q    <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        state_q <= EXEC;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                        gnt0_q  <= ~win1_d;
                        gnt1_q  <= win1_d;
                        last_q  <= win1_d;
                        owner_q <= win1_d;
                        cnt_q   <= LAT_C;
                        op_q    <= win1_d ? bus.op1 : bus.op0;
                        a_q     <= win1_d ? bus.a1  : bus.a0;
                        b_q     <= win1_d ? bus.b1  : bus.b0;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                EXEC: begin
                    // Operands stay put; the result is captured on the last count.
                    if (cnt_q == 4'd1) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        res_q   <= bus.alu_res;
                        flag_q  <= bus.alu_flag;
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [7:0] cnt0_q;
    logic [7:0] cnt1_q;

    // Saturating grant-pulse counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else begin
            if (gnt0_q && (cnt0_q != 8'd255)) begin
                cnt0_q <= cnt0_q + 8'd1;
            end
            if (gnt1_q && (cnt1_q != 8'd255)) begin
                cnt1_q <= cnt1_q + 8'd1;
            end
        end
    end

    assign cnt0_o = cnt0_q;
    assign cnt1_o = cnt1_q;
`endif

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.res       = res_q;
    assign bus.res_flag  = flag_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_start = start_q;
    assign bus.busy      = busy_q;

endmodule
